// File: rtl/vga_scanout.sv
// VGA raster generator: drives x/y scan coordinates into the sprite cluster and
// registers the returned colour and syncs one pixel period later.
module vga_scanout #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int PIX_DIV     = 4,
  parameter int INT_WIDTH   = 16,
  parameter int COLOR_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [INT_WIDTH-1:0]     x,
  output logic [INT_WIDTH-1:0]     y,
  input  logic [COLOR_WIDTH-1:0]   pixel,
  output logic [COLOR_WIDTH/3-1:0] vga_r,
  output logic [COLOR_WIDTH/3-1:0] vga_g,
  output logic [COLOR_WIDTH/3-1:0] vga_b,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     vblank,
  output logic                     frame_start
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int CW3     = COLOR_WIDTH / 3;

  logic [DIV_W-1:0]     div;
  logic [INT_WIDTH-1:0] hcnt, vcnt;
  logic                 first_tick;
  logic                 tick, h_last, v_last, active, hs_n, vs_n;

  assign tick   = (div == DIV_W'(PIX_DIV - 1));
  assign h_last = (hcnt == INT_WIDTH'(H_TOTAL - 1));
  assign v_last = (vcnt == INT_WIDTH'(V_TOTAL - 1));
  assign active = (hcnt < INT_WIDTH'(H_VISIBLE)) && (vcnt < INT_WIDTH'(V_VISIBLE));
  assign hs_n   = !((hcnt >= INT_WIDTH'(H_VISIBLE + H_FRONT)) &&
                    (hcnt <  INT_WIDTH'(H_VISIBLE + H_FRONT + H_SYNC)));
  assign vs_n   = !((vcnt >= INT_WIDTH'(V_VISIBLE + V_FRONT)) &&
                    (vcnt <  INT_WIDTH'(V_VISIBLE + V_FRONT + V_SYNC)));

  // The counters are the coordinate registers, so x/y and vblank stay aligned.
  assign x      = hcnt;
  assign y      = vcnt;
  assign vblank = (vcnt >= INT_WIDTH'(V_VISIBLE));

  always_ff @(posedge clk) begin
    if (!rst) begin
      div         <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      first_tick  <= 1'b1;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (tick) begin
        div         <= '0;
        first_tick  <= 1'b0;
        frame_start <= first_tick | (h_last & v_last);
        if (h_last) begin
          hcnt <= '0;
          vcnt <= v_last ? '0 : vcnt + INT_WIDTH'(1);
        end else begin
          hcnt <= hcnt + INT_WIDTH'(1);
        end
        // Output stage captures the pixel period that is ending on this tick.
        vga_r <= active ? pixel[COLOR_WIDTH-1 -: CW3] : '0;
        vga_g <= active ? pixel[2*CW3-1 -: CW3]       : '0;
        vga_b <= active ? pixel[CW3-1:0]              : '0;
        hsync <= hs_n;
        vsync <= vs_n;
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_vga_scanout.sv
// Self-checking bench for vga_scanout: fixed checkpoint table, randomized
// frames against an arithmetic raster model, and reset corner sequences.
module tb_vga_scanout;
  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 4, VF = 1, VS = 2, VB = 1;
  localparam int PD = 2, IW = 16, CW = 12;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [IW-1:0] x, y;
  logic [CW-1:0] pixel = '0;
  logic [3:0]    vga_r, vga_g, vga_b;
  logic          hsync, vsync, vblank, frame_start;

  int errors = 0;
  int checks = 0;
  int c = 0;      // posedges seen with rst high since the last reset edge
  int pmode = 0;  // 0: constant ABC, 1: coord pattern / random alternating frames
  logic [CW-1:0] hist [0:4095];

  always #5 clk = ~clk;

  vga_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .PIX_DIV(PD), .INT_WIDTH(IW), .COLOR_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .pixel(pixel),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync(hsync), .vsync(vsync), .vblank(vblank), .frame_start(frame_start)
  );

  typedef struct {
    int         c;
    int         ex, ey;
    logic [11:0] rgb;
    bit         hs, vs, vb, fs;
  } vec_t;
  vec_t vecs [16];

  // Raster position after t pixel ticks, from plain arithmetic.
  function automatic int px(int t); return (t % FT) % HT; endfunction
  function automatic int py(int t); return (t % FT) / HT; endfunction
  function automatic bit act_at(int t); return px(t) < HV && py(t) < VV; endfunction
  function automatic bit hs_at(int t); return !(px(t) >= HV + HF && px(t) < HV + HF + HS); endfunction
  function automatic bit vs_at(int t); return !(py(t) >= VV + VF && py(t) < VV + VF + VS); endfunction

  function automatic logic [47:0] pk(int xx, int yy, logic [11:0] rgb, bit hs, bit vs, bit vb, bit fs);
    logic [15:0] a, b;
    a = xx[15:0];
    b = yy[15:0];
    return {a, b, rgb, hs, vs, vb, fs};
  endfunction

  function automatic logic [47:0] dut_out();
    return {x, y, vga_r, vga_g, vga_b, hsync, vsync, vblank, frame_start};
  endfunction

  function automatic logic [CW-1:0] gen_pix(int t);
    logic [31:0] xv, yv, r;
    if (pmode == 0) return 12'hABC;
    if (((t / FT) % 2) == 0) begin
      xv = px(t);
      yv = py(t);
      return {xv[3:0], yv[3:0], 4'h5};
    end
    r = $urandom;
    return r[CW-1:0];
  endfunction

  task automatic chk(string name, logic [47:0] act, logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (c=%0d)", name, act, exp, c);
    end
  endtask

  task automatic step();
    int t;
    @(posedge clk);
    if (rst) c++;
    else c = 0;
    #1;
    if (c % PD == 0) begin
      t = c / PD;
      pixel = gen_pix(t);
      hist[t % 4096] = pixel;
    end
  endtask

  task automatic check_model(string name);
    int t, q;
    logic [11:0] rgb, pv;
    bit hs, vs, fs;
    t = c / PD;
    rgb = '0; hs = 1'b1; vs = 1'b1;
    if (t > 0) begin
      q = t - 1;
      pv = hist[q % 4096];
      rgb = act_at(q) ? pv : 12'h000;
      hs = hs_at(q);
      vs = vs_at(q);
    end
    fs = (c % PD == 0) && (t > 0) && (t == 1 || t % FT == 0);
    chk(name, dut_out(), pk(px(t), py(t), rgb, hs, vs, py(t) >= VV, fs));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] held;
    int fs_c;
    bit found;

    // checkpoints with pixel tied to 12'hABC: c, x, y, rgb, hs, vs, vb, fs
    vecs[0]  = '{0,   0, 0, 12'h000, 1, 1, 0, 0};
    vecs[1]  = '{2,   1, 0, 12'hABC, 1, 1, 0, 1};
    vecs[2]  = '{3,   1, 0, 12'hABC, 1, 1, 0, 0};
    vecs[3]  = '{16,  8, 0, 12'hABC, 1, 1, 0, 0};
    vecs[4]  = '{18,  9, 0, 12'h000, 1, 1, 0, 0};
    vecs[5]  = '{22, 11, 0, 12'h000, 0, 1, 0, 0};
    vecs[6]  = '{26, 13, 0, 12'h000, 0, 1, 0, 0};
    vecs[7]  = '{28, 14, 0, 12'h000, 1, 1, 0, 0};
    vecs[8]  = '{30,  0, 1, 12'h000, 1, 1, 0, 0};
    vecs[9]  = '{32,  1, 1, 12'hABC, 1, 1, 0, 0};
    vecs[10] = '{120, 0, 4, 12'h000, 1, 1, 1, 0};
    vecs[11] = '{152, 1, 5, 12'h000, 1, 0, 1, 0};
    vecs[12] = '{212, 1, 7, 12'h000, 1, 1, 1, 0};
    vecs[13] = '{240, 0, 0, 12'h000, 1, 1, 0, 1};
    vecs[14] = '{241, 0, 0, 12'h000, 1, 1, 0, 0};
    vecs[15] = '{242, 1, 0, 12'hABC, 1, 1, 0, 0};

    // reset held with pixel ABC: outputs at reset values
    pmode = 0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_hold", dut_out(), pk(0, 0, 12'h000, 1, 1, 0, 0));
    end
    rst = 1'b1;
    foreach (vecs[i]) begin
      while (c < vecs[i].c) begin
        step();
        check_model("model_const");
      end
      chk($sformatf("vec%0d", i), dut_out(),
          pk(vecs[i].ex, vecs[i].ey, vecs[i].rgb, vecs[i].hs, vecs[i].vs, vecs[i].vb, vecs[i].fs));
    end

    // randomized / coordinate-pattern frames against the model
    rst = 1'b0;
    pmode = 1;
    step();
    rst = 1'b1;
    for (int i = 0; i < 3 * FT * PD; i++) begin
      step();
      check_model("model_rand");
      if (c % PD == 0 && c / PD > 0 && ((c / PD - 1) / FT) % 2 == 0 &&
          px(c / PD - 1) == 3 && py(c / PD - 1) == 2)
        chk("rgb_at_3_2", {36'h0, vga_r, vga_g, vga_b}, 48'h325);
    end

    // one-clock reset at (6,2), then wait for the next wrap frame_start
    found = 1'b0;
    for (int i = 0; i < 2 * FT * PD && !found; i++) begin
      step();
      check_model("model_pre_rst");
      if (px(c / PD) == 6 && py(c / PD) == 2) found = 1'b1;
    end
    chk("reach_6_2", {47'h0, found}, 48'h1);
    rst = 1'b0;
    step();
    chk("mid_reset", dut_out(), pk(0, 0, 12'h000, 1, 1, 0, 0));
    rst = 1'b1;
    fs_c = -1;
    for (int i = 0; i < 400 && fs_c < 0; i++) begin
      step();
      check_model("model_post_rst");
      if (frame_start && c > PD) fs_c = c;
    end
    chk("fs_after_release", 48'(fs_c), 48'(FT * PD));

    // reset asserted between edges must not act before the next posedge
    for (int i = 0; i < 7; i++) step();
    @(negedge clk);
    held = dut_out();
    rst = 1'b0;
    #2;
    chk("async_rst_hold", dut_out(), held);
    step();
    check_model("sync_rst_edge");
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_model("model_resume");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Display-side consumer of the sprite cluster's coordinate/pixel interface.
- Generates VGA raster timing and drives the x/y scan coordinates into the cluster.
- Samples the returned pixel colour and emits registered RGB plus hsync/vsync to the board DAC.
- Exports vblank and frame_start so the CPU-side write path can schedule position/texture updates outside the visible region.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- PIX_DIV, 4, clk cycles per pixel period (100 MHz -> 25 MHz); must be >= 2
- INT_WIDTH, 16, coordinate width
- COLOR_WIDTH, 12, pixel width as {R,G,B}; equal thirds

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- x  out  INT_WIDTH  current scan column to cluster
- y  out  INT_WIDTH  current scan line to cluster
- pixel  in  COLOR_WIDTH  colour returned by cluster for (x,y); valid within PIX_DIV-1 clk of x/y change
- vga_r  out  COLOR_WIDTH/3  red
- vga_g  out  COLOR_WIDTH/3  green
- vga_b  out  COLOR_WIDTH/3  blue
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- vblank  out  1  high while vcnt >= V_VISIBLE
- frame_start  out  1  one-clk pulse when counters wrap to (0,0)

Behaviour:
- Reset (rst=0 at posedge): div, hcnt, vcnt, x, y = 0; vga_r/g/b = 0; hsync = vsync = 1; vblank = 0; frame_start = 0. Reset mid-line or mid-frame aborts immediately; scan restarts at (0,0) on the first cycle after release.
- Pixel tick: div counts 0..PIX_DIV-1 and wraps; tick = (div == PIX_DIV-1). All raster state advances only on tick; between ticks all outputs hold.
- H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters.
- On tick, hcnt increments. At H_TOTAL-1, hcnt wraps to 0 and vcnt increments; vcnt wraps to 0 at V_TOTAL-1.
- x, y: registered copies of hcnt, vcnt (zero-extended). They are driven during blanking too; the cluster's output there is ignored.
- active = (hcnt < H_VISIBLE) && (vcnt < V_VISIBLE).
- hs_n = 0 iff H_VISIBLE+H_FRONT <= hcnt < H_VISIBLE+H_FRONT+H_SYNC.
- vs_n = 0 iff V_VISIBLE+V_FRONT <= vcnt < V_VISIBLE+V_FRONT+V_SYNC.
- Output stage: on tick, registers sample pixel for the coordinate presented during the ending pixel period, together with that period's active/hs_n/vs_n. Latency from x/y to RGB/syncs is exactly one pixel period (PIX_DIV clk).
- RGB split: vga_r = pixel[MSB third], vga_g = middle third, vga_b = LSB third. All three are forced to 0 when the sampled active = 0.
- vblank: combinational from vcnt, so it aligns with x/y, not with the delayed RGB.
- frame_start: high for the single clk in which x/y become (0,0) through wrap, and also on the first tick after reset.
- Simultaneous horizontal and vertical wrap (last pixel of last line): both wrap on the same tick. frame_start is asserted; no intermediate state (0, V_TOTAL) is ever visible.
- Arithmetic: counters are INT_WIDTH wide, unsigned. Sync and porch comparisons are unsigned against parameter sums.

Test Plan:
Sim parameters: H 8/2/3/2 (H_TOTAL 15), V 4/1/2/1 (V_TOTAL 8), PIX_DIV 2, COLOR_WIDTH 12.
1. Reset release, pixel tied to 12'hABC -> RGB 0 and syncs 1 during reset. x advances 0,1,2... every 2 clk. One pixel period after x=0, vga_r/g/b = A/B/C for 8 consecutive pixel periods, then 0.
2. Run one full line -> hsync low for exactly 3 pixel periods (6 clk), starting one pixel period after x=10. x wraps 14->0 and y increments 0->1 on the same tick.
3. Run a full frame (120 pixel periods = 240 clk) -> vsync low while delayed vcnt is 5..6. vblank is high for y=4..7. frame_start pulses once, 240 clk apart, coincident with x=y=0.
4. Drive pixel = {x[3:0],y[3:0],4'h5} from a model -> at (x=3,y=2) the RGB one pixel later is 3/2/5. Pixel at x=8 or y=4 yields RGB 0.
5. Assert rst=0 for 1 clk at x=6,y=2 -> next cycle x=y=0, RGB 0, syncs 1. Timing resumes cleanly; the next frame_start arrives 240 clk after release.
6. Assert rst=0 asynchronously between clk edges -> no output change until the next posedge; this confirms synchronous reset.
